// File: rtl/seq_detect_ctrl_if.sv
// Word-in / result-out handshake bundle for the 1011 sequence detector.
interface seq_detect_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serialises each input word MSB first through an overlapping 1011 Mealy detector,
// reporting per-word match counts and a saturating running total.
module seq_detect_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    seq_detect_ctrl_if.slave   bus,
    output logic               match,
    output logic [CNT_W-1:0]   total_count,
    output logic               busy
);

    localparam int unsigned IDX_W  = $clog2(WIDTH + 1);
    localparam int unsigned OCNT_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
    typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

    ctrl_t             state;
    det_t              det;
    det_t              det_nxt;
    logic              hit_c;
    logic [WIDTH-1:0]  sreg;
    logic [IDX_W-1:0]  idx;
    logic              x;
    logic              shift_en;
    logic              last_bit;
    logic              hit_eff;

    assign x        = sreg[WIDTH-1];
    assign shift_en = (state == SHIFT);
    assign last_bit = (idx == IDX_W'(WIDTH - 1));
    // A clear on the same edge as a hit swallows the hit entirely.
    assign hit_eff  = shift_en & hit_c & ~clr;

    // Detector transition and match decode for the bit currently at the MSB.
    always_comb begin
        det_nxt = det;
        hit_c   = 1'b0;
        case (det)
            S0:   det_nxt = x ? S1   : S0;
            S1:   det_nxt = x ? S1   : S10;
            S10:  det_nxt = x ? S101 : S0;
            S101: begin
                det_nxt = x ? S1 : S10;
                hit_c   = x;
            end
            default: det_nxt = S0;
        endcase
    end

    // Controller: accept a word, shift WIDTH bits, hold the result until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sreg          <= '0;
            idx           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg          <= bus.in_data;
                        idx           <= '0;
                        bus.out_count <= '0;
                        bus.in_ready  <= 1'b0;
                        busy          <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    idx  <= idx + IDX_W'(1);
                    if (hit_eff) begin
                        bus.out_count <= bus.out_count + OCNT_W'(1);
                    end
                    if (last_bit) begin
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Detector state persists across words; only shift edges advance it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det         <= S0;
            match       <= 1'b0;
            total_count <= '0;
        end else begin
            match <= 1'b0;
            if (clr) begin
                det         <= S0;
                total_count <= '0;
            end else if (shift_en) begin
                det <= det_nxt;
                if (hit_c) begin
                    match <= 1'b1;
                    if (total_count != {CNT_W{1'b1}}) begin
                        total_count <= total_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed table, mid-word reset, and random words vs a stream model.
module tb_seq_detect_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;

    logic             match;
    logic [15:0]      total_count;
    logic             busy;
    logic             match2;
    logic [1:0]       total_count2;
    logic             busy2;

    int tests;
    int fails;

    // Model: bits seen since the last clear/reset, trimmed to the last four.
    bit hist[$];
    int model_total;

    seq_detect_ctrl_if #(.WIDTH(WIDTH)) bus  ();
    seq_detect_ctrl_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus.in_valid   = in_valid;
    assign bus.in_data    = in_data;
    assign bus.out_ready  = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data;
    assign bus2.out_ready = out_ready;

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus),
        .match(match), .total_count(total_count), .busy(busy)
    );

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus2),
        .match(match2), .total_count(total_count2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         clr_before;
        logic [7:0] data;
        int         hold;
        int         exp_cnt;
        int         exp_tot;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        model_total = 0;
    endtask

    task automatic model_word(input logic [7:0] d, output int n);
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            hist.push_back(d[i]);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] == 1'b1 && hist[1] == 1'b0 &&
                hist[2] == 1'b1 && hist[3] == 1'b1) n++;
        end
        model_total += n;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        chk("clr total", int'(total_count), 0);
        chk("clr total2", int'(total_count2), 0);
        chk("clr match", int'(match), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " in_ready"}, int'(bus.in_ready), 1);
        chk({tag, " out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " out_count"}, int'(bus.out_count), 0);
        chk({tag, " match"}, int'(match), 0);
        chk({tag, " total"}, int'(total_count), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " total2"}, int'(total_count2), 0);
    endtask

    // exp_cnt / exp_tot of -1 take the model's prediction.
    task automatic run_word(input logic [7:0] d, input int exp_cnt, input int exp_tot,
                            input int hold, input string tag);
        int mc;
        int lat;
        int pulses;
        model_word(d, mc);
        if (exp_cnt < 0) exp_cnt = mc;
        if (exp_tot < 0) exp_tot = model_total;
        chk({tag, " in_ready idle"}, int'(bus.in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " in_ready shift"}, int'(bus.in_ready), 0);
        lat    = 0;
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            lat++;
            if (match) pulses++;
            if (bus.out_valid) break;
        end
        chk({tag, " latency"}, lat, WIDTH);
        chk({tag, " out_count"}, int'(bus.out_count), exp_cnt);
        chk({tag, " match pulses"}, pulses, exp_cnt);
        chk({tag, " total"}, int'(total_count), exp_tot);
        chk({tag, " total2"}, int'(total_count2), sat3(exp_tot));
        chk({tag, " out_count2"}, int'(bus2.out_count), exp_cnt);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            tick();
            chk({tag, " hold out_valid"}, int'(bus.out_valid), 1);
            chk({tag, " hold out_count"}, int'(bus.out_count), exp_cnt);
            chk({tag, " hold in_ready"}, int'(bus.in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " consumed out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " consumed in_ready"}, int'(bus.in_ready), 1);
        chk({tag, " consumed busy"}, int'(busy), 0);
    endtask

    initial begin
        int rc;
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();

        vecs[0] = '{1'b0, 8'b1011_0000, 0, 1, 1};
        vecs[1] = '{1'b0, 8'b1011_0110, 0, 2, 3};
        vecs[2] = '{1'b0, 8'b0000_0101, 0, 0, 3};
        vecs[3] = '{1'b0, 8'b1000_0000, 0, 1, 4};
        vecs[4] = '{1'b0, 8'b1111_1111, 5, 0, 4};
        vecs[5] = '{1'b1, 8'b1011_1011, 0, 2, 2};
        vecs[6] = '{1'b0, 8'b1011_1011, 0, 2, 4};
        vecs[7] = '{1'b0, 8'b0000_0101, 0, 0, 4};
        vecs[8] = '{1'b1, 8'b1000_0000, 0, 0, 0};

        repeat (2) tick();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        check_reset_outputs("reset");
        in_valid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr_before) clr_pulse();
            run_word(vecs[i].data, vecs[i].exp_cnt, vecs[i].exp_tot, vecs[i].hold,
                     $sformatf("vec%0d", i));
        end

        // Reset after the 4th shift edge of a word: nothing may be reported for it.
        in_valid = 1'b1;
        in_data  = 8'b1011_0110;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        tick();
        tick();
        rst = 1'b1;
        run_word(8'b1000_1011, 1, 1, 0, "post_reset");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) clr_pulse();
            rc = int'($urandom_range(0, 3));
            run_word(8'($urandom), -1, -1, rc, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8: bits per input word, legal range 2..255.
REQ-002 The module SHALL take parameter CNT_W, default 16: width of the running match total.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_data  input  WIDTH  word to scan, MSB first.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 out_valid  output  1  per-word result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_count  output  8  number of matches found in the last word.
REQ-011 match  output  1  one-cycle pulse per detected pattern.
REQ-012 total_count  output  CNT_W  saturating running match total.
REQ-013 clr  input  1  synchronous clear of total_count and detector state.
REQ-014 busy  output  1  high whenever the controller is not in IDLE.

Function
REQ-015 The controller FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 IDLE behaviour:
- in_ready=1.
- On an edge with in_valid=1: load in_data into the shift register, clear the bit index and the per-word count, and go to SHIFT.
REQ-017 SHIFT behaviour:
- Each edge presents the shift-register MSB as bit x to the detector, shifts left and increments the bit index.
- On the WIDTH-th SHIFT edge, go to DONE.
REQ-018 DONE behaviour:
- out_valid=1, with out_count stable.
- On an edge with out_ready=1, go to IDLE.
- With out_ready=0, out_valid and out_count SHALL hold indefinitely.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; no word is accepted until the result is consumed.
REQ-020 Latency: out_valid SHALL first be high after exactly WIDTH edges following the accepting edge. Throughput is one word per WIDTH+2 cycles when out_ready=1.
REQ-021 The detector SHALL be a Mealy FSM for pattern 1011, overlapping, with states S0, S1, S10, S101:
- S0: x=1 -> S1; x=0 -> S0.
- S1: x=1 -> S1; x=0 -> S10.
- S10: x=1 -> S101; x=0 -> S0.
- S101: x=1 -> S1 with a match; x=0 -> S10.
REQ-022 The detector SHALL advance only on SHIFT edges.
REQ-023 Detector state SHALL persist across words, so a pattern spanning a word boundary counts toward the later word.
REQ-024 On a match edge:
- match is high for the following cycle.
- out_count increments by 1.
- total_count increments by 1, saturating at all ones with no wrap.
REQ-025 clr=1 on an edge:
- total_count is set to 0 and the detector is set to S0.
- clr wins over a simultaneous match: no increment and no match pulse.
- The controller FSM, shift register and out_count are unaffected.

Reset
REQ-026 While rst=0, the block SHALL force:
- controller FSM to IDLE and detector to S0;
- in_ready=1, out_valid=0, out_count=0, match=0, total_count=0, busy=0.
REQ-027 A reset asserted mid-SHIFT or in DONE SHALL discard the word in progress without producing a result.
REQ-028 The first word SHALL be accepted on the first edge after reset release at which in_valid=1.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- 8'b10110000, out_ready=1 -> out_valid 8 edges after acceptance; out_count=1; total_count=1; one match pulse.
- 8'b10110110 -> out_count=2, confirming overlap; total_count increments by 2.
- 8'b00000101 then 8'b10000000 -> first out_count=0, second out_count=1, confirming cross-word detection.
- out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_count held constant; in_ready=0 and in_valid ignored.
- CNT_W=2, 8'b10111011 sent twice -> out_count=2 each time; total_count saturates at 3; clr then gives total_count=0.
- rst pulsed low at the 4th SHIFT edge -> all outputs at reset values; a new word is accepted and counted from S0.
